// File: rtl/rx_sched_pkg.sv
// Shared definitions for the RX packet scheduler.
//   - sched_state_e  : arbitration FSM state encoding (IDLE/OFFER/BUSY)
//   - CTRL_CHAN_CODE : header channel code used for the control FIFO (index 0)
//   - DEF_FULL_WORDS / DEF_OVR_WORDS : default FIFO fill thresholds
//   - chan_code()    : FIFO index -> header channel code
package rx_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    BUSY  = 2'd2
  } sched_state_e;

  localparam logic [4:0] CTRL_CHAN_CODE = 5'h1f;
  localparam int         DEF_FULL_WORDS = 504;
  localparam int         DEF_OVR_WORDS  = 1000;

  // Radio channels are numbered from 0 in the header, so FIFO index i maps to i-1;
  // the control FIFO gets its own reserved code.
  function automatic logic [4:0] chan_code(input logic [3:0] idx);
    logic [4:0] code;
    if (idx == 4'd0) begin
      code = CTRL_CHAN_CODE;
    end else begin
      code = {1'b0, idx} - 5'd1;
    end
    return code;
  endfunction

endpackage

// File: rtl/rx_packet_scheduler_rr_pick.sv
// Combinational rotate-priority picker.
//   elig_i  : eligibility vector, one bit per index
//   start_i : index searched first
//   limit_i : highest index in the rotation; the search wraps to 0 after it
//   found_o : some index in 0..limit_i is eligible
//   idx_o   : first eligible index at or after start_i (with wrap)
// A start beyond the limit is treated as 0; a limit beyond N-1 is clamped.
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = 4
) (
  input  logic [N-1:0]  elig_i,
  input  logic [IW-1:0] start_i,
  input  logic [IW-1:0] limit_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  localparam int           CW  = IW + 1;
  localparam logic [IW-1:0] TOP = IW'(N - 1);

  logic [IW-1:0] lim_s;
  logic [IW-1:0] start_s;
  logic [CW-1:0] cand_s;
  logic          hit_s;

  // Clamp the rotation limit to the real index range and fold an out-of-range start to 0.
  always_comb begin
    lim_s   = (limit_i > TOP) ? TOP : limit_i;
    start_s = (start_i > lim_s) ? {IW{1'b0}} : start_i;
  end

  // Walk N candidates from the start, wrapping after the limit; first hit wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = {IW{1'b0}};
    cand_s  = {CW{1'b0}};
    hit_s   = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand_s = {1'b0, start_s} + CW'(k);
      if (cand_s > {1'b0, lim_s}) begin
        cand_s = cand_s - ({1'b0, lim_s} + {{IW{1'b0}}, 1'b1});
      end else begin
        cand_s = cand_s;
      end
      hit_s = 1'b0;
      for (int j = 0; j < N; j++) begin
        hit_s = hit_s | ((cand_s == CW'(j)) & elig_i[j]);
      end
      if (!found_o && hit_s) begin
        found_o = 1'b1;
        idx_o   = cand_s[IW-1:0];
      end else begin
        found_o = found_o;
      end
    end
  end

endmodule

// File: rtl/rx_packet_scheduler.sv
// RX packet scheduler: picks which channel FIFO the packet builder serves next.
// Ports:
//   rxclk, reset_n      : clock, asynchronous active-low reset
//   enable, channels    : arbitration enable, highest grantable FIFO index
//   chan_usedw, chan_empty : per-FIFO fill level (10 bits each) and empty flag
//   have_space          : USB side can take one more packet
//   grant_valid/sel/channel/partial/overrun : offer to the builder
//   grant_ack, pkt_done : builder handshake pulses
//   overrun             : sticky per-channel overrun flags (bit 0 always 0)
//   busy                : an offer or packet is in progress
module rx_packet_scheduler
  import rx_sched_pkg::*;
#(
  parameter int NUM_CHAN     = 2,
  parameter int FULL_WORDS   = DEF_FULL_WORDS,
  parameter int OVR_WORDS    = DEF_OVR_WORDS,
  parameter int FLUSH_CYCLES = 4096
) (
  input  logic                     rxclk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic [3:0]               channels,
  input  logic [10*(NUM_CHAN+1)-1:0] chan_usedw,
  input  logic [NUM_CHAN:0]        chan_empty,
  input  logic                     have_space,
  output logic                     grant_valid,
  output logic [3:0]               grant_sel,
  output logic [4:0]               grant_channel,
  output logic                     grant_partial,
  output logic                     grant_overrun,
  input  logic                     grant_ack,
  input  logic                     pkt_done,
  output logic [NUM_CHAN:0]        overrun,
  output logic                     busy
);

  localparam int             NCH      = NUM_CHAN + 1;
  localparam int             AW       = $clog2(FLUSH_CYCLES + 1);
  localparam logic [9:0]     FULL_LVL = 10'(FULL_WORDS);
  localparam logic [9:0]     OVR_LVL  = 10'(OVR_WORDS);
  localparam logic [AW-1:0]  AGE_MAX  = AW'(FLUSH_CYCLES);
  localparam logic [AW-1:0]  AGE_ONE  = {{(AW-1){1'b0}}, 1'b1};

  sched_state_e    state_q, state_d;
  logic [3:0]      rr_ptr_q, rr_ptr_d;
  logic            grant_valid_q, grant_valid_d;
  logic [3:0]      grant_sel_q, grant_sel_d;
  logic [4:0]      grant_channel_q, grant_channel_d;
  logic            grant_partial_q, grant_partial_d;
  logic            busy_q, busy_d;
  logic [NUM_CHAN:0] overrun_q, overrun_d;
  logic [AW-1:0]   age_q [NCH];
  logic [AW-1:0]   age_d [NCH];

  logic [9:0]      usedw_s [NCH];
  logic [NUM_CHAN:0] elig_s;
  logic            pick_found_s;
  logic [3:0]      pick_idx_s;
  logic            pick_partial_s;
  logic            ack_acc_s;
  logic            sel_ovr_s;

  for (genvar g = 0; g < NCH; g++) begin : g_unpack
    assign usedw_s[g] = chan_usedw[10*g +: 10];
  end

  // An ack only counts while an offer is actually pending.
  assign ack_acc_s = grant_ack & (state_q == OFFER);

  // Eligibility: data present, in range, room upstream, and either a full payload or aged out.
  always_comb begin
    elig_s = {NCH{1'b0}};
    for (int i = 0; i < NCH; i++) begin
      elig_s[i] = ~chan_empty[i] & (4'(i) <= channels) & have_space &
                  ((usedw_s[i] >= FULL_LVL) | (age_q[i] == AGE_MAX));
    end
  end

  rr_pick #(
    .N  (NCH),
    .IW (4)
  ) u_rr_pick (
    .elig_i  (elig_s),
    .start_i (rr_ptr_q),
    .limit_i (channels),
    .found_o (pick_found_s),
    .idx_o   (pick_idx_s)
  );

  // Partial flag and live overrun of the selected channel, via one-hot muxes.
  always_comb begin
    pick_partial_s = 1'b0;
    sel_ovr_s      = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      pick_partial_s = pick_partial_s | ((pick_idx_s == 4'(i)) & (usedw_s[i] < FULL_LVL));
      sel_ovr_s      = sel_ovr_s | ((grant_sel_q == 4'(i)) & overrun_q[i]);
    end
  end

  // Age counters and sticky overrun flags; overrun set beats the ack clear.
  always_comb begin
    overrun_d = {NCH{1'b0}};
    for (int i = 0; i < NCH; i++) begin
      if (chan_empty[i] || (ack_acc_s && (grant_sel_q == 4'(i)))) begin
        age_d[i] = {AW{1'b0}};
      end else if ((usedw_s[i] < FULL_LVL) && (age_q[i] != AGE_MAX)) begin
        age_d[i] = age_q[i] + AGE_ONE;
      end else begin
        age_d[i] = age_q[i];
      end
      if (i == 0) begin
        overrun_d[i] = 1'b0;
      end else if ((usedw_s[i] >= OVR_LVL) || ((usedw_s[i] >= FULL_LVL) && !have_space)) begin
        overrun_d[i] = 1'b1;
      end else if (ack_acc_s && (grant_sel_q == 4'(i))) begin
        overrun_d[i] = 1'b0;
      end else begin
        overrun_d[i] = overrun_q[i];
      end
    end
  end

  // Arbitration FSM next-state and grant fields.
  always_comb begin
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    grant_valid_d   = grant_valid_q;
    grant_sel_d     = grant_sel_q;
    grant_channel_d = grant_channel_q;
    grant_partial_d = grant_partial_q;
    case (state_q)
      IDLE: begin
        if (enable && pick_found_s) begin
          state_d         = OFFER;
          grant_valid_d   = 1'b1;
          grant_sel_d     = pick_idx_s;
          grant_channel_d = chan_code(pick_idx_s);
          grant_partial_d = pick_partial_s;
        end else begin
          grant_valid_d = 1'b0;
        end
      end
      OFFER: begin
        if (grant_ack) begin
          state_d       = BUSY;
          grant_valid_d = 1'b0;
        end else if (!enable) begin
          state_d       = IDLE;
          grant_valid_d = 1'b0;
        end else begin
          grant_valid_d = 1'b1;
        end
      end
      BUSY: begin
        if (pkt_done) begin
          state_d  = IDLE;
          rr_ptr_d = (grant_sel_q == channels) ? 4'd0 : (grant_sel_q + 4'd1);
        end else begin
          state_d = BUSY;
        end
      end
      default: begin
        state_d       = IDLE;
        grant_valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, grant and status registers.
  always_ff @(posedge rxclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      rr_ptr_q        <= 4'd0;
      grant_valid_q   <= 1'b0;
      grant_sel_q     <= 4'd0;
      grant_channel_q <= 5'd0;
      grant_partial_q <= 1'b0;
      busy_q          <= 1'b0;
      overrun_q       <= {NCH{1'b0}};
      for (int i = 0; i < NCH; i++) begin
        age_q[i] <= {AW{1'b0}};
      end
    end else begin
      state_q         <= state_d;
      rr_ptr_q        <= rr_ptr_d;
      grant_valid_q   <= grant_valid_d;
      grant_sel_q     <= grant_sel_d;
      grant_channel_q <= grant_channel_d;
      grant_partial_q <= grant_partial_d;
      busy_q          <= busy_d;
      overrun_q       <= overrun_d;
      for (int i = 0; i < NCH; i++) begin
        age_q[i] <= age_d[i];
      end
    end
  end

  assign grant_valid   = grant_valid_q;
  assign grant_sel     = grant_sel_q;
  assign grant_channel = grant_channel_q;
  assign grant_partial = grant_partial_q;
  assign grant_overrun = (grant_sel_q == 4'd0) ? 1'b0 : sel_ovr_s;
  assign overrun       = overrun_q;
  assign busy          = busy_q;

endmodule
